alu_seq_driver: RTL and testbench
=================================

Name: alu_seq_driver

Overview:
Hardware command initiator and checker for ALU_32. It accepts one operation command at a time over a valid/ready handshake and drives A, in0, in1 and select onto the ALU. It waits a fixed ALU latency, samples the ALU result and compares it with the command's expected value under a bit mask. It returns a response over a second valid/ready handshake and keeps pass/fail statistics. It sits between a command source (CPU, ROM sequencer or bench) and the ALU_32 instance.

Parameters:
DATA_W, 32, operand/result width
SEL_W, 3, ALU select width
ALU_LATENCY, 1, cycles from operands driven to o_out valid; legal range 0..15
CNT_W, 16, width of pass/fail counters

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  block can accept command
i_cmd_A  in  DATA_W  operand A
i_cmd_in0  in  DATA_W  operand in0
i_cmd_in1  in  DATA_W  operand in1
i_cmd_select  in  SEL_W  ALU operation select
i_cmd_expected  in  DATA_W  expected result
i_cmd_mask  in  DATA_W  compare mask (1 = bit checked)
o_alu_A  out  DATA_W  to ALU i_A
o_alu_in0  out  DATA_W  to ALU i_in0
o_alu_in1  out  DATA_W  to ALU i_in1
o_alu_select  out  SEL_W  to ALU i_select
i_alu_out  in  DATA_W  from ALU o_out
o_rsp_valid  out  1  response present
i_rsp_ready  in  1  response consumed
o_rsp_result  out  DATA_W  sampled ALU result
o_rsp_pass  out  1  1 = masked match
o_rsp_index  out  8  sequence number of command
i_clear_counts  in  1  zero both counters
o_pass_count  out  CNT_W  passing commands
o_fail_count  out  CNT_W  failing commands
o_busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; index counter 0. o_cmd_ready is 1 in the first cycle after reset deasserts.
- FSM states: IDLE, WAIT, REPORT.
- IDLE: o_cmd_ready=1. If i_cmd_valid=1, capture all command fields at that edge (cycle T). Operands appear on o_alu_* from cycle T+1 (cycle D). Go to WAIT with the latency counter loaded with ALU_LATENCY.
- WAIT: o_cmd_ready=0. Decrement the counter each cycle. Sample i_alu_out at the rising edge ending cycle D+ALU_LATENCY. ALU_LATENCY=0 means sampling at the end of D, i.e. a combinational ALU. At that edge go to REPORT.
- REPORT: o_rsp_valid=1. o_rsp_result, o_rsp_pass and o_rsp_index are held stable until i_rsp_ready=1. On the handshake edge, go to IDLE and drop o_rsp_valid. i_rsp_ready held high gives back-to-back operation of ALU_LATENCY+3 cycles per command.
- pass = (((i_alu_out ^ expected) & mask) == 0). mask=0 always passes.
- Counters: o_pass_count or o_fail_count increments by 1 at the sample edge. Both saturate at 2^CNT_W-1, with no wrap.
- i_clear_counts zeros both counters next edge. If clear coincides with an increment, clear wins and the result is 0.
- o_rsp_index: an 8-bit counter assigned at command acceptance. The first command gets 0; it wraps 255->0.
- o_alu_* hold the last command's operands after the response; they only change on a new acceptance.
- i_cmd_valid in WAIT/REPORT is ignored and not captured. The source must hold it until ready.
- Reset mid-operation drops the in-flight command: no response, counters and index zero, o_alu_* zero.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, REPORT=2'd2)
  - DATA_W/SEL_W defaults
  - index width constant (8)
- One sub-module: alu_seq_sat_counter (CNT_W, inc, clear, synchronous reset, saturating). It is instanced twice, for pass and fail.
- Compare logic is inline.

Test Plan:
- Reset then single command, stub ALU = registered in0+in1, LAT=1: A=0xD6, in0=0xD4, in1=0xD5, select=3'b001, expected=0x1A9, mask=0xFFFFFFFF. Required: o_alu_in0=0xD4 at D; rsp_valid at D+2; result=0x1A9; pass=1; index=0; pass_count=1.
- Mismatch under mask: expected=0x1A8. With mask=0xFFFFFFFF the response has pass=0 and fail_count increments. With mask=0xFFFFFFFE, pass=1.
- Response backpressure: hold i_rsp_ready=0 for 5 cycles. Required: rsp fields stable, cmd_ready=0, and a second cmd_valid is not accepted. After ready=1 the next command is accepted the following cycle with index=1.
- Latency sweep ALU_LATENCY=0 and 4: the result is sampled at the end of D and of D+4 respectively. A stub that changes output one cycle late yields pass=0 exactly when expected.
- Counter boundaries:
  - CNT_W=4, 17 passing commands: pass_count saturates at 15.
  - i_clear_counts coincident with a pass sample: the count reads 0.
  - 257 commands: index wraps to 0 on the 257th.
- Reset in WAIT: assert i_reset for 1 cycle mid-wait. Required: no rsp_valid ever for that command, all outputs 0, and cmd_ready=1 the next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU_32 command initiator/checker.
// Holds the FSM state encoding and default widths.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 3;
    localparam int IDX_W      = 8;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear dominates a coincident increment.
module alu_seq_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    // count up, stick at all-ones, clear/reset win over increment
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Drives one command at a time into ALU_32, samples the result after a
// fixed latency, compares it under a mask and returns a response.
module alu_seq_driver
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SEL_W       = SEL_W_DEF,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [DATA_W-1:0] i_cmd_A,
    input  logic [DATA_W-1:0] i_cmd_in0,
    input  logic [DATA_W-1:0] i_cmd_in1,
    input  logic [SEL_W-1:0]  i_cmd_select,
    input  logic [DATA_W-1:0] i_cmd_expected,
    input  logic [DATA_W-1:0] i_cmd_mask,
    output logic [DATA_W-1:0] o_alu_A,
    output logic [DATA_W-1:0] o_alu_in0,
    output logic [DATA_W-1:0] o_alu_in1,
    output logic [SEL_W-1:0]  o_alu_select,
    input  logic [DATA_W-1:0] i_alu_out,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_result,
    output logic              o_rsp_pass,
    output logic [IDX_W-1:0]  o_rsp_index,
    input  logic              i_clear_counts,
    output logic [CNT_W-1:0]  o_pass_count,
    output logic [CNT_W-1:0]  o_fail_count,
    output logic              o_busy
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LATENCY);

    state_t              state;
    state_t              state_nx;
    logic                accept;
    logic                sample;
    logic                pass_now;
    logic [LAT_W-1:0]    lat_cnt;
    logic [IDX_W-1:0]    idx_cnt;
    logic [DATA_W-1:0]   exp_q;
    logic [DATA_W-1:0]   mask_q;

    assign pass_now = (((i_alu_out ^ exp_q) & mask_q) == '0);
    assign o_busy   = (state != IDLE);

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next state, handshake outputs and sample strobe
    always_comb begin
        state_nx    = state;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        accept      = 1'b0;
        sample      = 1'b0;
        unique case (state)
            IDLE: begin
                o_cmd_ready = ~i_reset;
                if (i_cmd_valid && !i_reset) begin
                    accept   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    sample   = 1'b1;
                    state_nx = REPORT;
                end
            end
            REPORT: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // command capture, latency countdown and response capture
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_A      <= '0;
            o_alu_in0    <= '0;
            o_alu_in1    <= '0;
            o_alu_select <= '0;
            exp_q        <= '0;
            mask_q       <= '0;
            lat_cnt      <= '0;
            idx_cnt      <= '0;
            o_rsp_index  <= '0;
            o_rsp_result <= '0;
            o_rsp_pass   <= 1'b0;
        end else begin
            if (accept) begin
                o_alu_A      <= i_cmd_A;
                o_alu_in0    <= i_cmd_in0;
                o_alu_in1    <= i_cmd_in1;
                o_alu_select <= i_cmd_select;
                exp_q        <= i_cmd_expected;
                mask_q       <= i_cmd_mask;
                lat_cnt      <= LAT_INIT;
                o_rsp_index  <= idx_cnt;
                idx_cnt      <= idx_cnt + IDX_W'(1);
            end else if (state == WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (sample) begin
                o_rsp_result <= i_alu_out;
                o_rsp_pass   <= pass_now;
            end
        end
    end

    alu_seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_pass_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (sample & pass_now),
        .i_clear (i_clear_counts),
        .o_count (o_pass_count)
    );

    alu_seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_fail_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (sample & ~pass_now),
        .i_clear (i_clear_counts),
        .o_count (o_fail_count)
    );

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver: three instances (latency 1/0/4)
// each driving an adder stub that can be made one cycle late.
module tb_alu_seq_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_A, cmd_in0, cmd_in1, cmd_exp, cmd_mask;
    logic [2:0]  cmd_sel;

    logic        cmd_valid [3];
    logic        cmd_ready [3];
    logic        rsp_ready [3];
    logic        rsp_valid [3];
    logic        clr       [3];
    logic        late      [3];
    logic        busy      [3];
    logic [31:0] alu_A     [3];
    logic [31:0] alu_in0   [3];
    logic [31:0] alu_in1   [3];
    logic [2:0]  alu_sel   [3];
    logic [31:0] alu_out   [3];
    logic [31:0] rsp_res   [3];
    logic        rsp_pass  [3];
    logic [7:0]  rsp_idx   [3];
    logic [15:0] pass_cnt  [3];
    logic [15:0] fail_cnt  [3];

    int compared = 0;
    int mism     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 4);
        localparam int CW  = (g == 0) ? 16 : 4;
        localparam int LI  = (LAT == 0) ? 0 : LAT - 1;
        logic [CW-1:0] pc, fc;
        logic [31:0]   sum;
        logic [31:0]   pipe [5];
        logic [31:0]   aout;

        alu_seq_driver #(
            .DATA_W(32), .SEL_W(3), .ALU_LATENCY(LAT), .CNT_W(CW)
        ) u_dut (
            .i_clk          (clk),
            .i_reset        (reset),
            .i_cmd_valid    (cmd_valid[g]),
            .o_cmd_ready    (cmd_ready[g]),
            .i_cmd_A        (cmd_A),
            .i_cmd_in0      (cmd_in0),
            .i_cmd_in1      (cmd_in1),
            .i_cmd_select   (cmd_sel),
            .i_cmd_expected (cmd_exp),
            .i_cmd_mask     (cmd_mask),
            .o_alu_A        (alu_A[g]),
            .o_alu_in0      (alu_in0[g]),
            .o_alu_in1      (alu_in1[g]),
            .o_alu_select   (alu_sel[g]),
            .i_alu_out      (alu_out[g]),
            .o_rsp_valid    (rsp_valid[g]),
            .i_rsp_ready    (rsp_ready[g]),
            .o_rsp_result   (rsp_res[g]),
            .o_rsp_pass     (rsp_pass[g]),
            .o_rsp_index    (rsp_idx[g]),
            .i_clear_counts (clr[g]),
            .o_pass_count   (pc),
            .o_fail_count   (fc),
            .o_busy         (busy[g])
        );

        assign sum = alu_in0[g] + alu_in1[g];
        always @(posedge clk) begin
            pipe[0] <= sum;
            for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
        end
        assign aout = late[g] ? pipe[LAT] : ((LAT == 0) ? sum : pipe[LI]);
        assign alu_out[g]  = aout;
        assign pass_cnt[g] = 16'(pc);
        assign fail_cnt[g] = 16'(fc);
    end

    task automatic do_cmd(input int k, input logic [31:0] a, i0, i1,
                          input logic [2:0] sel, input logic [31:0] ex, mk,
                          input bit clr_d,
                          output logic [31:0] res, output logic ps,
                          output logic [7:0] ix, output logic [31:0] in0_d,
                          output int dly);
        int n;
        cmd_A = a; cmd_in0 = i0; cmd_in1 = i1; cmd_sel = sel;
        cmd_exp = ex; cmd_mask = mk;
        cmd_valid[k] = 1'b1;
        n = 0;
        while (!cmd_ready[k] && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        in0_d = alu_in0[k];
        clr[k] = clr_d;
        dly = 0;
        while (!rsp_valid[k] && dly < 40) begin
            @(negedge clk);
            clr[k] = 1'b0;
            dly++;
        end
        clr[k] = 1'b0;
        compared++;
        if (rsp_valid[k] !== 1'b1) begin
            mism++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid=%b want 1", k, rsp_valid[k]);
        end
        res = rsp_res[k]; ps = rsp_pass[k]; ix = rsp_idx[k];
        if (rsp_ready[k]) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({cmd_ready[0], rsp_valid[0], busy[0]} !== 3'b000) begin
            mism++;
            $display("FAIL reset_flags: got %b want 000",
                     {cmd_ready[0], rsp_valid[0], busy[0]});
        end
        compared++;
        if (alu_in0[0] !== 32'h0 || rsp_idx[0] !== 8'h0 || pass_cnt[0] !== 16'h0) begin
            mism++;
            $display("FAIL reset_regs: in0=%h idx=%h pc=%h want 0",
                     alu_in0[0], rsp_idx[0], pass_cnt[0]);
        end
        reset = 1'b0;
        #1;
        compared++;
        if (cmd_ready[0] !== 1'b1) begin
            mism++;
            $display("FAIL ready_after_reset: got %b want 1", cmd_ready[0]);
        end
    endtask

    task automatic test_single();
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly;
        @(negedge clk);
        do_cmd(0, 32'hD6, 32'hD4, 32'hD5, 3'b001, 32'h1A9, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (d0 !== 32'hD4 || alu_A[0] !== 32'hD6 || alu_sel[0] !== 3'b001) begin
            mism++;
            $display("FAIL single_ops: in0=%h A=%h sel=%b want d4 d6 001",
                     d0, alu_A[0], alu_sel[0]);
        end
        compared++;
        if (dly !== 2) begin
            mism++;
            $display("FAIL single_latency: got %0d want 2", dly);
        end
        compared++;
        if (r !== 32'h1A9 || p !== 1'b1 || ix !== 8'd0) begin
            mism++;
            $display("FAIL single_rsp: res=%h pass=%b idx=%0d want 1a9 1 0", r, p, ix);
        end
        compared++;
        if (pass_cnt[0] !== 16'd1 || fail_cnt[0] !== 16'd0) begin
            mism++;
            $display("FAIL single_counts: pc=%0d fc=%0d want 1 0", pass_cnt[0], fail_cnt[0]);
        end
    endtask

    task automatic test_mismatch();
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly;
        do_cmd(0, 32'hD6, 32'hD4, 32'hD5, 3'b001, 32'h1A8, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (p !== 1'b0 || ix !== 8'd1 || fail_cnt[0] !== 16'd1) begin
            mism++;
            $display("FAIL mismatch_full: pass=%b idx=%0d fc=%0d want 0 1 1", p, ix, fail_cnt[0]);
        end
        do_cmd(0, 32'hD6, 32'hD4, 32'hD5, 3'b001, 32'h1A8, 32'hFFFF_FFFE,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (p !== 1'b1 || ix !== 8'd2 || pass_cnt[0] !== 16'd2) begin
            mism++;
            $display("FAIL mismatch_masked: pass=%b idx=%0d pc=%0d want 1 2 2", p, ix, pass_cnt[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly; int n;
        rsp_ready[0] = 1'b0;
        do_cmd(0, 32'h0, 32'h10, 32'h20, 3'b001, 32'h30, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        cmd_in0 = 32'h1; cmd_in1 = 32'h2; cmd_exp = 32'h3;
        cmd_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            compared++;
            if (rsp_res[0] !== 32'h30 || rsp_idx[0] !== 8'd3 ||
                rsp_pass[0] !== 1'b1 || rsp_valid[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
                mism++;
                $display("FAIL bp_hold c%0d: res=%h idx=%0d pass=%b v=%b rdy=%b want 30 3 1 1 0",
                         c, rsp_res[0], rsp_idx[0], rsp_pass[0], rsp_valid[0], cmd_ready[0]);
            end
        end
        compared++;
        if (alu_in0[0] !== 32'h10) begin
            mism++;
            $display("FAIL bp_no_capture: in0=%h want 10", alu_in0[0]);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        compared++;
        if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
            mism++;
            $display("FAIL bp_release: v=%b rdy=%b want 0 1", rsp_valid[0], cmd_ready[0]);
        end
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        compared++;
        if (alu_in0[0] !== 32'h1 || busy[0] !== 1'b1) begin
            mism++;
            $display("FAIL bp_next_accept: in0=%h busy=%b want 1 1", alu_in0[0], busy[0]);
        end
        n = 0;
        while (!rsp_valid[0] && n < 20) begin @(negedge clk); n++; end
        compared++;
        if (rsp_valid[0] !== 1'b1 || rsp_idx[0] !== 8'd4 || rsp_res[0] !== 32'h3) begin
            mism++;
            $display("FAIL bp_next_rsp: v=%b idx=%0d res=%h want 1 4 3",
                     rsp_valid[0], rsp_idx[0], rsp_res[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n; logic [7:0] last;
        n = 0; last = 8'hFF;
        cmd_in0 = 32'h40; cmd_in1 = 32'h1; cmd_exp = 32'h41; cmd_mask = 32'hFFFF_FFFF;
        cmd_valid[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid[0]) begin n++; last = rsp_idx[0]; end
            if (c == 11) cmd_valid[0] = 1'b0;
            @(negedge clk);
        end
        compared++;
        if (n !== 3 || last !== 8'd7) begin
            mism++;
            $display("FAIL b2b_rate: rsps=%0d last_idx=%0d want 3 7", n, last);
        end
        compared++;
        if (pass_cnt[0] !== 16'd7 || fail_cnt[0] !== 16'd1) begin
            mism++;
            $display("FAIL b2b_counts: pc=%0d fc=%0d want 7 1", pass_cnt[0], fail_cnt[0]);
        end
    endtask

    task automatic test_latency();
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly;
        do_cmd(1, 32'h0, 32'h5, 32'h6, 3'b001, 32'hB, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (dly !== 1 || r !== 32'hB || p !== 1'b1 || ix !== 8'd0) begin
            mism++;
            $display("FAIL lat0_ok: dly=%0d res=%h pass=%b idx=%0d want 1 b 1 0", dly, r, p, ix);
        end
        late[1] = 1'b1;
        do_cmd(1, 32'h0, 32'h7, 32'h8, 3'b001, 32'hF, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        late[1] = 1'b0;
        compared++;
        if (r !== 32'hB || p !== 1'b0) begin
            mism++;
            $display("FAIL lat0_late: res=%h pass=%b want b 0", r, p);
        end
        do_cmd(2, 32'h0, 32'h100, 32'h200, 3'b001, 32'h300, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (dly !== 5 || r !== 32'h300 || p !== 1'b1) begin
            mism++;
            $display("FAIL lat4_ok: dly=%0d res=%h pass=%b want 5 300 1", dly, r, p);
        end
        late[2] = 1'b1;
        do_cmd(2, 32'h0, 32'h11, 32'h22, 3'b001, 32'h33, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        late[2] = 1'b0;
        compared++;
        if (r !== 32'h300 || p !== 1'b0 || fail_cnt[2] !== 16'd1) begin
            mism++;
            $display("FAIL lat4_late: res=%h pass=%b fc=%0d want 300 0 1", r, p, fail_cnt[2]);
        end
    endtask

    task automatic test_counters();
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly;
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        compared++;
        if (pass_cnt[1] !== 16'd0 || fail_cnt[1] !== 16'd0) begin
            mism++;
            $display("FAIL clear: pc=%0d fc=%0d want 0 0", pass_cnt[1], fail_cnt[1]);
        end
        for (int i = 0; i < 17; i++) begin
            do_cmd(1, 32'h0, i, 32'h1, 3'b001, i + 1, 32'hFFFF_FFFF,
                   1'b0, r, p, ix, d0, dly);
        end
        compared++;
        if (pass_cnt[1] !== 16'd15 || fail_cnt[1] !== 16'd0) begin
            mism++;
            $display("FAIL saturate: pc=%0d fc=%0d want 15 0", pass_cnt[1], fail_cnt[1]);
        end
        do_cmd(1, 32'h0, 32'h2, 32'h3, 3'b001, 32'h5, 32'hFFFF_FFFF,
               1'b1, r, p, ix, d0, dly);
        compared++;
        if (pass_cnt[1] !== 16'd0 || p !== 1'b1 || ix !== 8'd19) begin
            mism++;
            $display("FAIL clear_wins: pc=%0d pass=%b idx=%0d want 0 1 19", pass_cnt[1], p, ix);
        end
    endtask

    task automatic test_index_wrap();
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly;
        for (int i = 20; i < 256; i++) begin
            do_cmd(1, 32'h0, i, 32'h0, 3'b001, i, 32'hFFFF_FFFF,
                   1'b0, r, p, ix, d0, dly);
        end
        compared++;
        if (ix !== 8'd255) begin
            mism++;
            $display("FAIL index_255: got %0d want 255", ix);
        end
        do_cmd(1, 32'h0, 32'h9, 32'h9, 3'b001, 32'h12, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (ix !== 8'd0 || p !== 1'b1) begin
            mism++;
            $display("FAIL index_wrap: idx=%0d pass=%b want 0 1", ix, p);
        end
    endtask

    task automatic test_reset_wait();
        int seen;
        logic [31:0] r, d0; logic p; logic [7:0] ix; int dly;
        cmd_in0 = 32'h55; cmd_in1 = 32'h1; cmd_exp = 32'h56; cmd_A = 32'h77;
        cmd_sel = 3'b101; cmd_mask = 32'hFFFF_FFFF;
        cmd_valid[2] = 1'b1;
        @(negedge clk);
        cmd_valid[2] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({cmd_ready[2], rsp_valid[2], busy[2], rsp_pass[2]} !== 4'b0000 ||
            alu_A[2] !== 32'h0 || alu_in0[2] !== 32'h0 || alu_in1[2] !== 32'h0 ||
            alu_sel[2] !== 3'b000 || rsp_res[2] !== 32'h0 || rsp_idx[2] !== 8'h0 ||
            pass_cnt[2] !== 16'h0 || fail_cnt[2] !== 16'h0) begin
            mism++;
            $display("FAIL reset_wait_zero: rdy=%b v=%b busy=%b A=%h in0=%h idx=%0d pc=%0d fc=%0d",
                     cmd_ready[2], rsp_valid[2], busy[2], alu_A[2], alu_in0[2],
                     rsp_idx[2], pass_cnt[2], fail_cnt[2]);
        end
        reset = 1'b0;
        #1;
        compared++;
        if (cmd_ready[2] !== 1'b1) begin
            mism++;
            $display("FAIL reset_wait_ready: got %b want 1", cmd_ready[2]);
        end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid[2]) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mism++;
            $display("FAIL reset_wait_norsp: rsp cycles=%0d want 0", seen);
        end
        do_cmd(2, 32'h0, 32'h3, 32'h4, 3'b001, 32'h7, 32'hFFFF_FFFF,
               1'b0, r, p, ix, d0, dly);
        compared++;
        if (ix !== 8'd0 || p !== 1'b1 || pass_cnt[2] !== 16'd1) begin
            mism++;
            $display("FAIL reset_wait_restart: idx=%0d pass=%b pc=%0d want 0 1 1",
                     ix, p, pass_cnt[2]);
        end
    endtask

    initial begin
        cmd_A = '0; cmd_in0 = '0; cmd_in1 = '0; cmd_sel = '0;
        cmd_exp = '0; cmd_mask = '0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
            clr[k] = 1'b0; late[k] = 1'b0;
        end
        test_reset();
        test_single();
        test_mismatch();
        test_backpressure();
        test_back_to_back();
        test_latency();
        test_counters();
        test_index_wrap();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
